// File: rtl/regfile_alu_pipe.sv
// rtl/regfile_alu_pipe.sv - two-stage register-file + ALU execute unit with bypass, NZVC flags and output port
// Stage 1 captures operands (with bypass from the executing op); stage 2 computes and writes back.
module regfile_alu_pipe #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter bit R0_ZERO = 1'b0,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic              n,
  output logic              z,
  output logic              v,
  output logic              c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int H = DATA_W / 2;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_SAR = 4'hA, OP_LHI = 4'hB;
  localparam logic [3:0] OP_LLI = 4'hC, OP_MOV = 4'hD, OP_OUT = 4'hE;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_op_q, s1_op_d;
  logic [ADDR_W-1:0] s1_rd_q, s1_rd_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;

  logic n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;

  logic              res_valid_q, res_valid_d;
  logic [ADDR_W-1:0] res_rd_q, res_rd_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              stall;
  logic              exec;
  logic              ex_wr;
  logic              rf_we;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [DATA_W-1:0] b_eff;
  logic              cin;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign stall    = s1_valid_q && (s1_op_q == OP_OUT) && out_valid_q && !out_ready;
  assign exec     = s1_valid_q && !stall;
  assign in_ready = !stall;
  assign ex_wr    = exec && (s1_op_q <= OP_MOV);
  assign rf_we    = ex_wr && !(R0_ZERO && (s1_rd_q == '0));

  // SUB/SBB add the inverted operand; carry-in is 1 for SUB and the C flag for ADC/SBB.
  always_comb begin
    b_eff = ((s1_op_q == OP_SUB) || (s1_op_q == OP_SBB)) ? ~s1_b_q : s1_b_q;
    case (s1_op_q)
      OP_SUB:         cin = 1'b1;
      OP_ADC, OP_SBB: cin = c_q;
      default:        cin = 1'b0;
    endcase
    sum = {1'b0, s1_a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
  end

  always_comb begin
    alu_res = '0;
    alu_c   = c_q;
    alu_v   = 1'b0;
    case (s1_op_q)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (s1_a_q[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != s1_a_q[DATA_W-1]);
      end
      OP_AND: alu_res = s1_a_q & s1_b_q;
      OP_OR:  alu_res = s1_a_q | s1_b_q;
      OP_XOR: alu_res = s1_a_q ^ s1_b_q;
      OP_NOT: alu_res = ~s1_a_q;
      OP_SHL: begin
        alu_res = {s1_a_q[DATA_W-2:0], 1'b0};
        alu_c   = s1_a_q[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, s1_a_q[DATA_W-1:1]};
        alu_c   = s1_a_q[0];
      end
      OP_SAR: begin
        alu_res = {s1_a_q[DATA_W-1], s1_a_q[DATA_W-1:1]};
        alu_c   = s1_a_q[0];
      end
      OP_LHI:  alu_res = {s1_b_q[H-1:0], s1_a_q[H-1:0]};
      OP_LLI:  alu_res = {{(DATA_W-H){1'b0}}, s1_b_q[H-1:0]};
      OP_MOV:  alu_res = s1_b_q;
      default: alu_res = '0;
    endcase
  end

  // Operand read with bypass from the op writing back on the same edge.
  always_comb begin
    if (R0_ZERO && (ra == '0))            rd_a = '0;
    else if (rf_we && (s1_rd_q == ra))    rd_a = alu_res;
    else                                  rd_a = rf_q[ra];
    if (R0_ZERO && (rb == '0))            rd_b = '0;
    else if (rf_we && (s1_rd_q == rb))    rd_b = alu_res;
    else                                  rd_b = rf_q[rb];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_rd_d    = s1_rd_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (!stall) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op;
        s1_rd_d = rd;
        s1_a_d  = rd_a;
        s1_b_d  = use_imm ? imm : rd_b;
      end
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (rf_we) rf_d[s1_rd_q] = alu_res;
  end

  always_comb begin
    n_d = n_q;
    z_d = z_q;
    v_d = v_q;
    c_d = c_q;
    if (exec && (s1_op_q <= OP_SAR)) begin
      n_d = alu_res[DATA_W-1];
      z_d = (alu_res == '0);
      v_d = alu_v;
      c_d = alu_c;
    end
  end

  always_comb begin
    res_valid_d = ex_wr;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    if (ex_wr) begin
      res_rd_d   = s1_rd_q;
      res_data_d = alu_res;
    end
  end

  // A new OUT may load in the same edge the consumer takes the old value.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (exec && (s1_op_q == OP_OUT)) begin
      out_valid_d = 1'b1;
      out_data_d  = s1_a_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_rd_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      c_q         <= 1'b0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rf_q        <= rf_d;
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_rd_q     <= s1_rd_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      n_q         <= n_d;
      z_q         <= z_d;
      v_q         <= v_d;
      c_q         <= c_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_rd    = res_rd_q;
  assign res_data  = res_data_q;
  assign n         = n_q;
  assign z         = z_q;
  assign v         = v_q;
  assign c         = c_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_data  = (R0_ZERO && (dbg_addr == '0)) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// tb/tb_regfile_alu_pipe.sv - directed table-driven bench for regfile_alu_pipe
// Instance a has R0_ZERO=0, instance b has R0_ZERO=1; both receive identical stimulus.
module tb_regfile_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  op;
  logic [2:0]  rd, ra, rb;
  logic        use_imm;
  logic [15:0] imm;
  logic        out_ready;
  logic [2:0]  dbg_addr;

  logic        in_ready_a, res_valid_a, n_a, z_a, v_a, c_a, out_valid_a;
  logic [2:0]  res_rd_a;
  logic [15:0] res_data_a, out_data_a, dbg_data_a;
  logic        in_ready_b, res_valid_b, n_b, z_b, v_b, c_b, out_valid_b;
  logic [2:0]  res_rd_b;
  logic [15:0] res_data_b, out_data_b, dbg_data_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_alu_pipe #(.DATA_W(16), .NREGS(8), .R0_ZERO(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .op(op), .rd(rd),
    .ra(ra), .rb(rb), .use_imm(use_imm), .imm(imm), .res_valid(res_valid_a),
    .res_rd(res_rd_a), .res_data(res_data_a), .n(n_a), .z(z_a), .v(v_a), .c(c_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_a));

  regfile_alu_pipe #(.DATA_W(16), .NREGS(8), .R0_ZERO(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .op(op), .rd(rd),
    .ra(ra), .rb(rb), .use_imm(use_imm), .imm(imm), .res_valid(res_valid_b),
    .res_rd(res_rd_b), .res_data(res_data_b), .n(n_b), .z(z_b), .v(v_b), .c(c_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_b));

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic        ui;
    logic [15:0] imm;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [3:0]  exp_nzvc;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic ui, input logic [15:0] im);
    in_valid = 1'b1; op = o; rd = d; ra = a; rb = b; use_imm = ui; imm = im;
  endtask

  task automatic idle();
    in_valid = 1'b0; op = 4'hF; rd = 3'd0; ra = 3'd0; rb = 3'd0; use_imm = 1'b0; imm = 16'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic dbg_check(input string name, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(name, {16'h0, dbg_data_a}, {16'h0, exp});
  endtask

  initial begin
    // op, rd, ra, rb, use_imm, imm, exp_valid, exp_data, exp_nzvc
    vecs[0]  = '{4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0034, 1'b1, 16'h0034, 4'b0000};
    vecs[1]  = '{4'hB, 3'd1, 3'd1, 3'd0, 1'b1, 16'h0012, 1'b1, 16'h1234, 4'b0000};
    vecs[2]  = '{4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 4'b0000};
    vecs[3]  = '{4'hB, 3'd1, 3'd1, 3'd0, 1'b1, 16'h007F, 1'b1, 16'h7FFF, 4'b0000};
    vecs[4]  = '{4'h0, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 4'b1010};
    vecs[5]  = '{4'h1, 3'd3, 3'd1, 3'd1, 1'b0, 16'h0000, 1'b1, 16'h0000, 4'b0101};
    vecs[6]  = '{4'hC, 3'd4, 3'd0, 3'd0, 1'b1, 16'h00FF, 1'b1, 16'h00FF, 4'b0101};
    vecs[7]  = '{4'hB, 3'd4, 3'd4, 3'd0, 1'b1, 16'h00FF, 1'b1, 16'hFFFF, 4'b0101};
    vecs[8]  = '{4'h0, 3'd5, 3'd4, 3'd0, 1'b1, 16'h0001, 1'b1, 16'h0000, 4'b0101};
    vecs[9]  = '{4'h2, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b1, 16'h0001, 4'b0000};
    vecs[10] = '{4'h4, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b1, 16'h7FFE, 4'b0000};
    vecs[11] = '{4'h3, 3'd7, 3'd2, 3'd1, 1'b0, 16'h0000, 1'b1, 16'h7FFE, 4'b0011};
    vecs[12] = '{4'h8, 3'd7, 3'd2, 3'd0, 1'b0, 16'h0000, 1'b1, 16'hFFFC, 4'b1001};
    vecs[13] = '{4'hA, 3'd7, 3'd7, 3'd0, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 4'b1000};
    vecs[14] = '{4'h9, 3'd7, 3'd7, 3'd0, 1'b0, 16'h0000, 1'b1, 16'h7FFF, 4'b0000};
    vecs[15] = '{4'h6, 3'd6, 3'd6, 3'd0, 1'b1, 16'h0001, 1'b1, 16'h0000, 4'b0100};
    vecs[16] = '{4'h5, 3'd6, 3'd6, 3'd1, 1'b0, 16'h0000, 1'b1, 16'h7FFF, 4'b0000};
    vecs[17] = '{4'h7, 3'd6, 3'd6, 3'd0, 1'b0, 16'h0000, 1'b1, 16'h8000, 4'b1000};
    vecs[18] = '{4'hD, 3'd5, 3'd0, 3'd0, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 4'b1000};
    vecs[19] = '{4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b1000};

    out_ready = 1'b1;
    dbg_addr  = 3'd0;
    do_reset();

    check("rst_res_valid", {31'h0, res_valid_a}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid_a}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready_a}, 32'h1);
    check("rst_flags", {28'h0, n_a, z_a, v_a, c_a}, 32'h0);

    // Back-to-back table: vector i executes one edge after acceptance, so its
    // result is visible right after the edge that accepts vector i+1.
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) drive(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].ui, vecs[i].imm);
      else        idle();
      tick();
      if (i >= 1) begin
        check($sformatf("v%0d_valid", i - 1), {31'h0, res_valid_a}, {31'h0, vecs[i-1].exp_valid});
        if (vecs[i-1].exp_valid) begin
          check($sformatf("v%0d_data", i - 1), {16'h0, res_data_a}, {16'h0, vecs[i-1].exp_data});
          check($sformatf("v%0d_rd", i - 1), {29'h0, res_rd_a}, {29'h0, vecs[i-1].rd});
        end
        check($sformatf("v%0d_nzvc", i - 1), {28'h0, n_a, z_a, v_a, c_a}, {28'h0, vecs[i-1].exp_nzvc});
      end
    end
    idle();
    tick();
    dbg_check("dbg_r1", 3'd1, 16'h7FFF);
    dbg_check("dbg_r2", 3'd2, 16'hFFFE);
    dbg_check("dbg_r5", 3'd5, 16'hBEEF);
    dbg_check("dbg_r7", 3'd7, 16'h7FFF);

    // Output-port backpressure: second OUT stalls until out_ready.
    out_ready = 1'b0;
    drive(4'hE, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0);
    tick();
    drive(4'hE, 3'd0, 3'd2, 3'd0, 1'b0, 16'h0);
    tick();
    check("out1_valid", {31'h0, out_valid_a}, 32'h1);
    check("out1_data", {16'h0, out_data_a}, 32'h7FFF);
    check("out_no_res", {31'h0, res_valid_a}, 32'h0);
    drive(4'h0, 3'd3, 3'd1, 3'd1, 1'b0, 16'h0);
    #1;
    check("stall_in_ready", {31'h0, in_ready_a}, 32'h0);
    tick();
    check("stall_hold_data", {16'h0, out_data_a}, 32'h7FFF);
    check("stall_in_ready2", {31'h0, in_ready_a}, 32'h0);
    check("stall_no_res", {31'h0, res_valid_a}, 32'h0);
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {31'h0, in_ready_a}, 32'h1);
    tick();
    out_ready = 1'b0;
    idle();
    #1;
    check("out2_valid", {31'h0, out_valid_a}, 32'h1);
    check("out2_data", {16'h0, out_data_a}, 32'hFFFE);
    tick();
    check("post_add_valid", {31'h0, res_valid_a}, 32'h1);
    check("post_add_data", {16'h0, res_data_a}, 32'hFFFE);
    check("post_add_rd", {29'h0, res_rd_a}, 32'h3);
    out_ready = 1'b1;
    tick();
    check("out_drained", {31'h0, out_valid_a}, 32'h0);

    // Asynchronous reset with an ADD in flight.
    drive(4'h0, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0);
    tick();
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("arst_res_valid", {31'h0, res_valid_a}, 32'h0);
    check("arst_res_data", {16'h0, res_data_a}, 32'h0);
    check("arst_flags", {28'h0, n_a, z_a, v_a, c_a}, 32'h0);
    check("arst_out", {15'h0, out_valid_a, out_data_a}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("arst_no_write_valid", {31'h0, res_valid_a}, 32'h0);
    dbg_check("arst_r4", 3'd4, 16'h0000);
    dbg_check("arst_r1", 3'd1, 16'h0000);

    // r0 handling: b has hardwired zero, a has a real r0.
    drive(4'hD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h55AA);
    tick();
    drive(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0003);
    tick();
    idle();
    check("r0z_mov_valid", {31'h0, res_valid_b}, 32'h1);
    check("r0z_mov_data", {16'h0, res_data_b}, 32'h55AA);
    check("r0n_mov_data", {16'h0, res_data_a}, 32'h55AA);
    tick();
    check("r0z_add_data", {16'h0, res_data_b}, 32'h0003);
    check("r0n_add_data", {16'h0, res_data_a}, 32'h55AD);
    dbg_addr = 3'd0;
    #1;
    check("r0z_dbg_r0", {16'h0, dbg_data_b}, 32'h0);
    check("r0n_dbg_r0", {16'h0, dbg_data_a}, 32'h55AA);
    dbg_addr = 3'd1;
    #1;
    check("r0z_dbg_r1", {16'h0, dbg_data_b}, 32'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
